// File: rtl/spi_target_if.sv
// Bundles the SPI pins and CPU bus signals of the SPI target.
// The slave modport is the target's view; master is the CPU/SPI-master side.
interface spi_target_if;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        address;
    logic        read;
    logic        write;
    logic [3:0]  be;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    modport slave (
        input  sclk, ss_n, mosi, address, read, write, be, data_in,
        output miso, miso_oe, data_out, irq
    );

    modport master (
        output sclk, ss_n, mosi, address, read, write, be, data_in,
        input  miso, miso_oe, data_out, irq
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: shifts bytes in/out for an external master, queues received
// bytes in an RX FIFO and exposes DATA/STATUS registers plus an interrupt to the CPU.
module spi_target #(
    parameter int         RX_DEPTH  = 8,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    spi_target_if.slave  bus
);
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = AW + 1;

    // synchronisers: bit 0 is the first flop, edges compare stages 2 and 3
    logic [2:0]    r_sclk_pipe;
    logic [2:0]    r_ss_pipe;
    logic [1:0]    r_mosi_pipe;

    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_rx_shift;
    logic [6:0]    r_tx_shift;
    logic          r_miso;
    logic [7:0]    r_tx_hold;
    logic          r_tx_valid;

    logic [7:0]    r_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          r_read_d;
    logic [31:0]   r_data_out;
    logic          r_overrun;
    logic          r_ie;
    logic          r_irq;

    logic          w_sel;
    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_ss_fall;
    logic          w_ss_rise;
    logic          w_mosi_s;
    logic          w_fall_load;
    logic          w_tx_load;
    logic [7:0]    w_load_byte;
    logic [7:0]    w_rx_byte;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_nonempty;
    logic          w_read_rise;
    logic          w_tx_write;
    logic          w_ctrl_write;
    logic [7:0]    w_count8;
    logic [31:0]   w_status;
    logic          w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_pipe <= 3'b000;
            r_ss_pipe   <= 3'b111;
            r_mosi_pipe <= 2'b00;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[1:0], bus.sclk};
            r_ss_pipe   <= {r_ss_pipe[1:0], bus.ss_n};
            r_mosi_pipe <= {r_mosi_pipe[0], bus.mosi};
        end
    end

    assign w_sel       = ~r_ss_pipe[1];
    assign w_ss_fall   = ~r_ss_pipe[1] &  r_ss_pipe[2];
    assign w_ss_rise   =  r_ss_pipe[1] & ~r_ss_pipe[2];
    assign w_sclk_rise =  r_sclk_pipe[1] & ~r_sclk_pipe[2];
    assign w_sclk_fall = ~r_sclk_pipe[1] &  r_sclk_pipe[2];
    assign w_mosi_s    = r_mosi_pipe[1];

    // a falling sclk with bit_cnt==0 means a byte just completed: preload the next one
    assign w_fall_load = w_sel & w_sclk_fall & ~w_ss_fall & (r_bit_cnt == 3'd0);
    assign w_tx_load   = w_ss_fall | w_fall_load;
    assign w_load_byte = r_tx_valid ? r_tx_hold : IDLE_BYTE;
    assign w_rx_byte   = {r_rx_shift, w_mosi_s};
    assign w_push      = w_sel & w_sclk_rise & ~w_ss_fall & (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 7'd0;
            r_miso     <= 1'b0;
        end else if (w_ss_fall) begin
            r_bit_cnt  <= 3'd0;
            r_tx_shift <= w_load_byte[6:0];
            r_miso     <= w_load_byte[7];
        end else if (w_ss_rise) begin
            r_bit_cnt  <= 3'd0;
        end else if (w_sel && w_sclk_rise) begin
            r_rx_shift <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
        end else if (w_sel && w_sclk_fall) begin
            if (r_bit_cnt != 3'd0) begin
                r_miso     <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
            end else begin
                r_tx_shift <= w_load_byte[6:0];
                r_miso     <= w_load_byte[7];
            end
        end
    end

    assign w_tx_write   = bus.write & ~bus.address & bus.be[0];
    assign w_ctrl_write = bus.write &  bus.address;

    // a CPU write in the same clk as a load wins: shifter takes the old byte, new one stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_hold  <= 8'd0;
            r_tx_valid <= 1'b0;
        end else if (w_tx_write) begin
            r_tx_hold  <= bus.data_in[7:0];
            r_tx_valid <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign w_full      = (r_count == CW'(RX_DEPTH));
    assign w_nonempty  = (r_count != '0);
    assign w_read_rise = bus.read & ~r_read_d;
    assign w_pop       = w_read_rise & ~bus.address & w_nonempty;
    assign w_push_ok   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    generate
        if (CW >= 8) begin : g_cnt_wide
            assign w_count8 = r_count[7:0];
        end else begin : g_cnt_narrow
            assign w_count8 = {{(8 - CW){1'b0}}, r_count};
        end
    endgenerate

    assign w_status = {15'd0, r_ie, w_count8, 3'd0, w_sel, r_overrun,
                       ~r_tx_valid, w_full, w_nonempty};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_d   <= 1'b0;
            r_data_out <= 32'd0;
            r_overrun  <= 1'b0;
            r_ie       <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_read_d <= bus.read;
            if (w_read_rise) begin
                if (!bus.address) begin
                    r_data_out <= {23'd0, w_nonempty,
                                   (w_nonempty ? r_mem[r_rd_ptr] : 8'd0)};
                end else begin
                    r_data_out <= w_status;
                end
            end
            // a fresh overrun beats a simultaneous clear so no drop goes unreported
            if (w_push && !w_push_ok) begin
                r_overrun <= 1'b1;
            end else if (w_ctrl_write && bus.be[0] && bus.data_in[3]) begin
                r_overrun <= 1'b0;
            end
            if (w_ctrl_write && bus.be[2]) begin
                r_ie <= bus.data_in[16];
            end
            r_irq <= r_ie & (w_nonempty | r_overrun);
        end
    end

    assign bus.miso     = r_miso;
    assign bus.miso_oe  = w_sel;
    assign bus.data_out = r_data_out;
    assign bus.irq      = r_irq;

    assign w_unused = ^{bus.be[3], bus.be[1], bus.data_in[31:17], bus.data_in[15:8]};
endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: table-driven byte exchanges, hand sequences for
// the multi-cycle corners, and random traffic against a queue-based reference model.
module tb_spi_target;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    spi_target_if bus_if();

    spi_target #(.RX_DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_tx_valid;
    logic [7:0] m_tx;
    logic       m_overrun;
    logic       m_ie;

    logic [7:0] s_bytes [16];
    logic [7:0] s_miso  [16];
    logic [7:0] s_exp   [16];

    typedef struct {
        logic        preload;
        logic [7:0]  tx;
        logic [7:0]  mosi;
        logic [7:0]  exp_miso;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tx_valid = 1'b0;
        m_tx       = 8'h00;
        m_overrun  = 1'b0;
        m_ie       = 1'b0;
    endtask

    function automatic logic [31:0] model_status(input logic sel);
        logic [31:0] s;
        s        = '0;
        s[0]     = (m_q.size() != 0);
        s[1]     = (m_q.size() == DEPTH);
        s[2]     = ~m_tx_valid;
        s[3]     = m_overrun;
        s[4]     = sel;
        s[15:8]  = 8'(m_q.size());
        s[16]    = m_ie;
        return s;
    endfunction

    task automatic bus_write(input logic addr, input logic [3:0] be, input logic [31:0] data);
        bus_if.address = addr;
        bus_if.be      = be;
        bus_if.data_in = data;
        bus_if.write   = 1'b1;
        tick(1);
        bus_if.write   = 1'b0;
        if (!addr && be[0]) begin
            m_tx       = data[7:0];
            m_tx_valid = 1'b1;
        end
        if (addr) begin
            if (be[0] && data[3]) m_overrun = 1'b0;
            if (be[2]) m_ie = data[16];
        end
    endtask

    task automatic bus_read(input logic addr, output logic [31:0] data);
        bus_if.address = addr;
        bus_if.read    = 1'b1;
        tick(1);
        data           = bus_if.data_out;
        bus_if.read    = 1'b0;
        tick(1);
    endtask

    task automatic data_read_expect(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(1'b0, d);
        check(name, d, exp);
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    // mode 0 master, sclk = clk/10; miso is sampled just before each rising edge
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - nbits; b--) begin
            bus_if.mosi = tx[b];
            tick(5);
            rx[b] = bus_if.miso;
            bus_if.sclk = 1'b1;
            tick(5);
            bus_if.sclk = 1'b0;
        end
    endtask

    // one select window: nb full bytes from s_bytes, then an optional partial byte
    task automatic spi_session(input int nb, input int pbits);
        logic [7:0] dummy;
        s_exp[0] = m_tx_valid ? m_tx : 8'hFF;
        m_tx_valid = 1'b0;
        for (int k = 1; k < 16; k++) s_exp[k] = 8'hFF;
        bus_if.ss_n = 1'b0;
        tick(5);
        for (int k = 0; k < nb; k++) begin
            spi_byte(s_bytes[k], 8, s_miso[k]);
            if (m_q.size() < DEPTH) m_q.push_back(s_bytes[k]);
            else m_overrun = 1'b1;
        end
        if (pbits > 0) spi_byte(s_bytes[nb], pbits, dummy);
        tick(5);
        bus_if.ss_n = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [31:0] d;
        int nb, pb, op;

        vecs[0] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 32'h0000_01C3};
        vecs[1] = '{1'b0, 8'h00, 8'h3C, 8'hFF, 32'h0000_013C};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 32'h0000_01FF};
        vecs[3] = '{1'b1, 8'h81, 8'h00, 8'h81, 32'h0000_0100};
        vecs[4] = '{1'b1, 8'hA5, 8'h7E, 8'hA5, 32'h0000_017E};

        bus_if.sclk = 1'b0; bus_if.ss_n = 1'b1; bus_if.mosi = 1'b0;
        bus_if.address = 1'b0; bus_if.read = 1'b0; bus_if.write = 1'b0;
        bus_if.be = 4'h0; bus_if.data_in = 32'h0;
        model_reset();
        rst = 1'b1;
        tick(3);
        check("reset miso", {31'd0, bus_if.miso}, 32'd0);
        check("reset miso_oe", {31'd0, bus_if.miso_oe}, 32'd0);
        check("reset irq", {31'd0, bus_if.irq}, 32'd0);
        check("reset data_out", bus_if.data_out, 32'd0);
        rst = 1'b0;
        tick(2);
        bus_read(1'b1, d);
        check("reset status", d, 32'h0000_0004);

        // table: preload, one byte exchange, status, data read
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].preload) bus_write(1'b0, 4'b0001, {24'd0, vecs[i].tx});
            s_bytes[0] = vecs[i].mosi;
            spi_session(1, 0);
            check($sformatf("vec%0d miso", i), {24'd0, s_miso[0]}, {24'd0, vecs[i].exp_miso});
            bus_read(1'b1, d);
            check($sformatf("vec%0d status", i), d, 32'h0000_0105);
            data_read_expect($sformatf("vec%0d data", i), vecs[i].exp_data);
        end
        data_read_expect("empty data read", 32'h0);

        // selected flag, then three back-to-back bytes with no TX pending
        bus_if.ss_n = 1'b0;
        tick(5);
        bus_read(1'b1, d);
        check("status selected", d, 32'h0000_0014);
        bus_if.ss_n = 1'b1;
        tick(6);
        s_bytes[0] = 8'hA1; s_bytes[1] = 8'hB2; s_bytes[2] = 8'hC3;
        spi_session(3, 0);
        for (int k = 0; k < 3; k++)
            check($sformatf("b2b miso %0d", k), {24'd0, s_miso[k]}, 32'h0000_00FF);
        bus_read(1'b1, d);
        check("b2b status", d, 32'h0000_0305);
        data_read_expect("b2b data 0", 32'h0000_01A1);
        data_read_expect("b2b data 1", 32'h0000_01B2);
        data_read_expect("b2b data 2", 32'h0000_01C3);

        // overrun: DEPTH+1 bytes without reads
        for (int k = 0; k <= DEPTH; k++) s_bytes[k] = 8'h30 + 8'(k);
        spi_session(DEPTH + 1, 0);
        bus_read(1'b1, d);
        check("overrun status", d, 32'h0000_080F);
        bus_write(1'b1, 4'b0001, 32'h0000_0008);
        bus_read(1'b1, d);
        check("overrun cleared", d, 32'h0000_0807);
        for (int k = 0; k < DEPTH; k++)
            data_read_expect($sformatf("drain %0d", k), 32'h0000_0130 + 32'(k));
        data_read_expect("drained empty", 32'h0);

        // partial byte discarded, next byte intact
        s_bytes[0] = 8'hAA;
        spi_session(0, 5);
        bus_read(1'b1, d);
        check("partial no push", d, 32'h0000_0004);
        s_bytes[0] = 8'h11;
        spi_session(1, 0);
        data_read_expect("after partial", 32'h0000_0111);

        // multi-cycle read pops once
        s_bytes[0] = 8'h21; s_bytes[1] = 8'h42;
        spi_session(2, 0);
        bus_if.address = 1'b0;
        bus_if.read    = 1'b1;
        tick(1);
        d = bus_if.data_out;
        tick(3);
        bus_if.read = 1'b0;
        tick(1);
        check("held read data", d, 32'h0000_0121);
        void'(m_q.pop_front());
        bus_read(1'b1, d);
        check("held read count", d, 32'h0000_0105);
        data_read_expect("held read next", 32'h0000_0142);

        // interrupt
        bus_write(1'b1, 4'b0100, 32'h0001_0000);
        tick(2);
        check("irq idle", {31'd0, bus_if.irq}, 32'd0);
        s_bytes[0] = 8'h77;
        spi_session(1, 0);
        check("irq set", {31'd0, bus_if.irq}, 32'd1);
        data_read_expect("irq data", 32'h0000_0177);
        check("irq cleared", {31'd0, bus_if.irq}, 32'd0);

        // reset mid-byte
        s_bytes[0] = 8'h99;
        spi_session(1, 0);
        bus_read(1'b1, d);
        check("pre-reset status", d, 32'h0001_0105);
        bus_if.ss_n = 1'b0;
        tick(5);
        bus_if.mosi = 1'b1;
        tick(5);
        bus_if.sclk = 1'b1;
        tick(3);
        check("pre-reset miso", {31'd0, bus_if.miso}, 32'd1);
        check("pre-reset irq", {31'd0, bus_if.irq}, 32'd1);
        rst = 1'b1;
        #2;
        check("async rst miso", {31'd0, bus_if.miso}, 32'd0);
        check("async rst miso_oe", {31'd0, bus_if.miso_oe}, 32'd0);
        check("async rst irq", {31'd0, bus_if.irq}, 32'd0);
        check("async rst data_out", bus_if.data_out, 32'd0);
        bus_if.sclk = 1'b0; bus_if.ss_n = 1'b1; bus_if.mosi = 1'b0;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(2);
        bus_read(1'b1, d);
        check("post-reset status", d, 32'h0000_0004);

        // random traffic against the model
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: bus_write(1'b0, 4'b0001, $urandom);
                1, 2: begin
                    nb = $urandom_range(1, 3);
                    pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
                    for (int k = 0; k <= nb; k++) s_bytes[k] = 8'($urandom);
                    spi_session(nb, pb);
                    for (int k = 0; k < nb; k++)
                        check($sformatf("rnd%0d miso %0d", it, k),
                              {24'd0, s_miso[k]}, {24'd0, s_exp[k]});
                end
                3: data_read_expect($sformatf("rnd%0d data", it),
                       (m_q.size() != 0) ? {23'd0, 1'b1, m_q[0]} : 32'h0);
                4: begin
                    bus_read(1'b1, d);
                    check($sformatf("rnd%0d status", it), d, model_status(1'b0));
                end
                default: begin
                    bus_write(1'b1, ($urandom_range(0, 1) != 0) ? 4'b0101 : 4'b0100,
                              {15'd0, 1'($urandom), 12'd0, 1'($urandom), 3'd0});
                    tick(2);
                    check($sformatf("rnd%0d irq", it), {31'd0, bus_if.irq},
                          {31'd0, m_ie & ((m_q.size() != 0) | m_overrun)});
                end
            endcase
        end
        bus_read(1'b1, d);
        check("final status", d, model_status(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
